ccg_truth_table_sequencer: RTL and testbench
============================================

Name: ccg_truth_table_sequencer

Overview:
- Sequencer that drives a generated N_IN-input / N_OUT-output combinational circuit under test (CUT) through all 2^N_IN input vectors.
- Samples the CUT outputs after a programmable settle time and streams truth-table rows out over a valid/ready interface.
- Sits between a CUT instance (x0..x5 inputs, f1..f6 outputs) and the dataset capture/compare logic.

Parameters:
- N_IN, 6, CUT input count; vector counter width; 1..16.
- N_OUT, 6, CUT output count; row data width; 1..16.
- SETTLE_CYCLES, 1, cycles each vector is held before sampling; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep; ignored while busy.
- abort  input  1  cancels the sweep in progress.
- busy  output  1  high from the cycle after start is accepted until return to IDLE.
- done  output  1  one-cycle pulse after the last row handshake.
- dut_x  output  N_IN  registered vector driven into the CUT.
- dut_f  input  N_OUT  CUT outputs; combinational from dut_x.
- tt_valid  output  1  row available.
- tt_ready  input  1  consumer accepts the row.
- tt_addr  output  N_IN  input vector of the current row.
- tt_data  output  N_OUT  captured dut_f for that vector.
- signature  output  16  MISR over all accepted rows (optional feature).

Behaviour:
- Reset: state=IDLE; busy=0, done=0, tt_valid=0, dut_x=0, tt_addr=0, tt_data=0, signature=0.
- States and transitions:
  - IDLE: dut_x=0. start=1 moves to SETTLE with vec=0, settle_cnt=0, signature cleared.
  - SETTLE: dut_x=vec. settle_cnt counts 0..SETTLE_CYCLES-1. On the last count, capture dut_f into tt_data and vec into tt_addr, then go to EMIT.
  - EMIT: tt_valid=1. tt_addr, tt_data and dut_x stay stable until tt_ready=1.
    - On handshake with vec == 2^N_IN-1: go to DONE.
    - Otherwise: vec++, go to SETTLE. tt_valid drops in the next cycle.
  - DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Timing with tt_ready held at 1: start sampled at cycle 0, first SETTLE at cycle 1, row k valid at cycle SETTLE_CYCLES+1+k*(SETTLE_CYCLES+1), done one cycle after the final handshake.
  - For defaults: rows at cycles 2, 4, ..., 128; done at cycle 129.
- tt_valid never deasserts without a handshake, except on abort or reset.
- abort: takes priority over everything in any busy state. Next state is IDLE, tt_valid drops, no done pulse, dut_x returns to 0, and the partial signature is held.
- start while busy, or in the same cycle as abort: ignored.
- start in the DONE cycle: ignored. start is accepted only in IDLE.
- vec never wraps. The terminal compare prevents an increment past 2^N_IN-1.
- Asynchronous reset mid-sweep: immediate return to reset values; the sweep is not resumed.

Optional Feature:
- Macro: CCG_SIG_MISR_EN.
- Defined: on every accepted row, signature <= (signature<<1) ^ (signature[15] ? 16'h1021 : 16'h0) ^ zero_extend(tt_data). signature is cleared on start and held otherwise.
- Undefined: signature is tied to 0, and no MISR flops are present.

Decomposition:
- Package ccg_seq_pkg holds:
  - state enum {IDLE, SETTLE, EMIT, DONE};
  - SIG_W=16;
  - MISR_POLY=16'h1021;
  - a function computing the MISR step.
- Sub-module ccg_misr (16-bit, enable + clear) is instantiated only under CCG_SIG_MISR_EN.
- The FSM, vector counter and settle counter live in the top module.

Test Plan:
- Identity CUT (dut_f=dut_x), tt_ready=1, defaults, pulse start:
  - 64 handshakes, each with tt_data==tt_addr and addresses 0..63 in order;
  - done pulse at cycle 129 only; busy is low afterwards.
- Backpressure: tt_ready=0 for 5 cycles while row 3 is valid.
  - tt_valid, tt_addr=3, tt_data and dut_x=3 stay stable for all 5 cycles; row 4 follows normally.
- Abort asserted during the EMIT of row 10.
  - Next cycle: IDLE, busy=0, tt_valid=0, dut_x=0, no done pulse.
  - A new start then produces a full sweep beginning at address 0.
- start pulsed at rows 5 and 20 during a sweep, and again in the DONE cycle: all ignored, with a single sweep of 64 rows.
- SETTLE_CYCLES=3, registered-delay CUT model with 2-cycle latency: tt_data is correct for every row, and the row period is 4 cycles.
- With CCG_SIG_MISR_EN, constant-zero and identity CUTs: signature matches a bench reference model after done. rst asserted mid-sweep clears all outputs immediately.

Source files
------------

// File: rtl/ccg_seq_pkg.sv
// Shared types and MISR step for the truth-table sequencer.
// Signature accumulation is a CRC-16/CCITT-style shift with data folded in.
package ccg_seq_pkg;

  localparam int SIG_W = 16;
  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [SIG_W-1:0] din);
    return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0) ^ din;
  endfunction

endpackage

// File: rtl/ccg_misr.sv
// 16-bit MISR with synchronous clear and step enable; only built when
// CCG_SIG_MISR_EN is defined. Clear wins over enable.
module ccg_misr
  import ccg_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = misr_step(sig_q, din);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/ccg_truth_table_sequencer.sv
// Sweeps a combinational CUT through all 2^N_IN vectors and streams captured rows
// over valid/ready. Optional row signature built only under CCG_SIG_MISR_EN.
module ccg_truth_table_sequencer
  import ccg_seq_pkg::*;
#(
  parameter int N_IN          = 6,
  parameter int N_OUT         = 6,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  dut_x,
  input  logic [N_OUT-1:0] dut_f,
  output logic             tt_valid,
  input  logic             tt_ready,
  output logic [N_IN-1:0]  tt_addr,
  output logic [N_OUT-1:0] tt_data,
  output logic [SIG_W-1:0] signature
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_LAST    = '1;

  state_e           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [N_IN-1:0]  dut_x_q, dut_x_d;
  logic [N_IN-1:0]  tt_addr_q, tt_addr_d;
  logic [N_OUT-1:0] tt_data_q, tt_data_d;
  logic [CW-1:0]    settle_q, settle_d;
  logic             start_acc;
  logic             hs;
  logic             in_sweep;

  assign in_sweep  = (state_q == SETTLE) || (state_q == EMIT);
  assign start_acc = (state_q == IDLE) && start && !abort;
  assign hs        = (state_q == EMIT) && tt_ready && !abort;

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    dut_x_d   = dut_x_q;
    tt_addr_d = tt_addr_q;
    tt_data_d = tt_data_q;
    settle_d  = settle_q;
    case (state_q)
      IDLE: begin
        dut_x_d = '0;
        if (start_acc) begin
          state_d  = SETTLE;
          vec_d    = '0;
          settle_d = '0;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          tt_data_d = dut_f;
          tt_addr_d = vec_q;
          state_d   = EMIT;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      EMIT: begin
        // Terminal compare keeps vec from ever wrapping past the last vector.
        if (hs) begin
          if (vec_q == VEC_LAST) begin
            state_d = DONE;
            dut_x_d = '0;
          end else begin
            vec_d    = vec_q + 1'b1;
            dut_x_d  = vec_q + 1'b1;
            settle_d = '0;
            state_d  = SETTLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort && in_sweep) begin
      state_d = IDLE;
      dut_x_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      dut_x_q   <= '0;
      tt_addr_q <= '0;
      tt_data_q <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      dut_x_q   <= dut_x_d;
      tt_addr_q <= tt_addr_d;
      tt_data_q <= tt_data_d;
      settle_q  <= settle_d;
    end
  end

  assign busy     = in_sweep;
  assign done     = (state_q == DONE);
  assign tt_valid = (state_q == EMIT);
  assign dut_x    = dut_x_q;
  assign tt_addr  = tt_addr_q;
  assign tt_data  = tt_data_q;

`ifdef CCG_SIG_MISR_EN
  ccg_misr u_misr (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .en  (hs),
    .din (SIG_W'(tt_data_q)),
    .sig (signature)
  );
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_ccg_truth_table_sequencer.sv
// Bench: table of sweep scenarios on a default instance with a selectable CUT,
// plus a SETTLE_CYCLES=3 instance driving a two-stage registered CUT.
module tb_ccg_truth_table_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, tt_ready;
  logic        busy, done, tt_valid;
  logic [5:0]  dut_x, dut_f, tt_addr, tt_data;
  logic [15:0] signature;

  logic        start_1, abort_1, tt_ready_1;
  logic        busy_1, done_1, tt_valid_1;
  logic [5:0]  dut_x_1, dut_f_1, tt_addr_1, tt_data_1;
  logic [15:0] signature_1;
  logic [5:0]  pipe1, pipe2;

  logic [383:0] lut_flat;
  int           cut_mode;
  int           n_tests = 0;
  int           n_fail  = 0;

  typedef struct {
    int mode;       // 0 identity, 1 zero, 2 random lut, 3 inverted
    int ready_pct;
    int exp_done;   // expected done cycle, 0 = not checked
    int bp_row;     // row stalled for 5 cycles, -1 = none
    int abort_row;  // row aborted during EMIT, -1 = none
    int poke;       // pulse start at rows 5, 20 and in DONE
  } sweep_t;

  ccg_truth_table_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .dut_x(dut_x), .dut_f(dut_f), .tt_valid(tt_valid), .tt_ready(tt_ready),
    .tt_addr(tt_addr), .tt_data(tt_data), .signature(signature)
  );

  ccg_truth_table_sequencer #(.N_IN(6), .N_OUT(6), .SETTLE_CYCLES(3)) dut_s3 (
    .clk(clk), .rst(rst), .start(start_1), .abort(abort_1), .busy(busy_1), .done(done_1),
    .dut_x(dut_x_1), .dut_f(dut_f_1), .tt_valid(tt_valid_1), .tt_ready(tt_ready_1),
    .tt_addr(tt_addr_1), .tt_data(tt_data_1), .signature(signature_1)
  );

  assign dut_f = (cut_mode == 0) ? dut_x :
                 (cut_mode == 1) ? 6'd0 :
                 (cut_mode == 2) ? lut_flat[dut_x*6 +: 6] : ~dut_x;

  always_ff @(posedge clk) begin
    pipe1 <= lut_flat[dut_x_1*6 +: 6];
    pipe2 <= pipe1;
  end
  assign dut_f_1 = pipe2;

  function automatic logic [5:0] exp_f(input int k);
    case (cut_mode)
      0:       return 6'(k);
      1:       return 6'd0;
      2:       return lut_flat[k*6 +: 6];
      default: return 6'(63 - k);
    endcase
  endfunction

  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [5:0] d);
    int v;
    v = int'(s) * 2;
    if (v >= 65536) v = (v - 65536) ^ 'h1021;
    return 16'(v ^ int'(d));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_sig(input logic [15:0] model);
`ifdef CCG_SIG_MISR_EN
    chk("signature", int'(signature), int'(model));
`else
    chk("signature_tied", int'(signature), 0);
    if (model == 16'hffff) $display("note: unreachable model value");
`endif
  endtask

  task automatic randomize_lut();
    for (int i = 0; i < 64; i++) lut_flat[i*6 +: 6] = 6'($urandom_range(63));
  endtask

  task automatic run_sweep(input sweep_t s);
    int cyc, rows, bp_left;
    bit fin, pv, pr;
    logic [5:0] pa, pd, px;
    logic [15:0] sig_m;
    cut_mode = s.mode;
    if (s.mode == 2) randomize_lut();
    rows = 0; cyc = 0; bp_left = 5; fin = 0; pv = 0; pr = 1;
    pa = 0; pd = 0; px = 0; sig_m = 0;
    @(posedge clk); #1;
    start = 1; abort = 0; tt_ready = 1;
    while (!fin) begin
      @(posedge clk); #1;
      cyc++;
      start = 0; abort = 0;
      tt_ready = ($urandom_range(99) < s.ready_pct);
      if (s.bp_row >= 0 && tt_valid && tt_addr == 6'(s.bp_row) && bp_left > 0) begin
        tt_ready = 0;
        bp_left--;
      end
      if (s.poke != 0 && tt_valid && (tt_addr == 6'd5 || tt_addr == 6'd20)) start = 1;
      if (s.poke != 0 && done) start = 1;
      if (s.abort_row >= 0 && tt_valid && tt_addr == 6'(s.abort_row)) begin
        abort = 1;
        tt_ready = 0;
      end
      @(negedge clk);
      if (pv && !pr)
        chk("hold_stable", {tt_valid, tt_addr, tt_data, dut_x}, {1'b1, pa, pd, px});
      if (s.bp_row >= 0 && s.ready_pct == 100 && tt_valid && !tt_ready && !abort)
        chk("bp_row", {tt_addr, dut_x}, {6'(s.bp_row), 6'(s.bp_row)});
      if (tt_valid && tt_ready && !abort) begin
        chk("row", {busy, tt_addr, tt_data}, {1'b1, 6'(rows), exp_f(rows)});
        sig_m = sig_step(sig_m, exp_f(rows));
        rows++;
      end
      pv = tt_valid && !abort; pr = tt_ready;
      pa = tt_addr; pd = tt_data; px = dut_x;
      if (abort) begin
        @(posedge clk); #1;
        abort = 0; tt_ready = 1;
        @(negedge clk);
        chk("abort_idle", {busy, done, tt_valid, dut_x}, 0);
        chk_sig(sig_m);
        fin = 1;
      end else if (done) begin
        chk("row_count", rows, 64);
        if (s.exp_done > 0) chk("done_cycle", cyc, s.exp_done);
        chk("busy_at_done", int'(busy), 0);
        chk_sig(sig_m);
        repeat (4) begin
          @(posedge clk); #1;
          start = 0;
          @(negedge clk);
          chk("after_done", {busy, done, tt_valid}, 0);
        end
        fin = 1;
      end else if (cyc > 3000) begin
        chk("sweep_timeout", cyc, 0);
        fin = 1;
      end
    end
  endtask

  sweep_t tbl[8];

  initial begin
    int cyc, rows;
    bit fin;
    tbl[0] = '{0, 100, 129, -1, -1, 0};
    tbl[1] = '{0, 100, 134,  3, -1, 0};
    tbl[2] = '{0, 100,   0, -1, 10, 0};
    tbl[3] = '{0, 100, 129, -1, -1, 1};
    tbl[4] = '{1, 100, 129, -1, -1, 0};
    tbl[5] = '{2,  60,   0, -1, -1, 0};
    tbl[6] = '{3,  50,   0, -1, -1, 0};
    tbl[7] = '{2, 100, 129, -1, -1, 0};

    rst = 1; start = 0; abort = 0; tt_ready = 0; cut_mode = 0;
    start_1 = 0; abort_1 = 0; tt_ready_1 = 1;
    randomize_lut();
    #1;
    chk("reset_outs", {busy, done, tt_valid, dut_x, tt_addr, tt_data}, 0);
    chk("reset_sig", int'(signature), 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < 8; i++) run_sweep(tbl[i]);

    // Asynchronous reset in the middle of a sweep.
    cut_mode = 0;
    @(posedge clk); #1;
    start = 1; tt_ready = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (30) @(posedge clk);
    #1;
    chk("busy_mid", int'(busy), 1);
    rst = 1;
    #1;
    chk("rst_mid_outs", {busy, done, tt_valid, dut_x, tt_addr, tt_data}, 0);
    chk("rst_mid_sig", int'(signature), 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      chk("no_resume", {busy, tt_valid}, 0);
    end
    run_sweep(tbl[0]);

    // SETTLE_CYCLES=3 instance against a two-cycle registered CUT.
    randomize_lut();
    @(posedge clk); #1;
    start_1 = 1;
    cyc = 0; rows = 0; fin = 0;
    while (!fin) begin
      @(posedge clk); #1;
      start_1 = 0;
      cyc++;
      @(negedge clk);
      if (tt_valid_1) begin
        chk("s3_row", {tt_addr_1, tt_data_1}, {6'(rows), lut_flat[rows*6 +: 6]});
        chk("s3_period", cyc, 4 + 4 * rows);
        rows++;
      end
      if (done_1) begin
        chk("s3_rows", rows, 64);
        chk("s3_done_cycle", cyc, 257);
        fin = 1;
      end else if (cyc > 3000) begin
        chk("s3_timeout", cyc, 0);
        fin = 1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
